line_mem_responder: RTL and testbench
=====================================

// Module: line_mem_responder
// PURPOSE
//  Backing-memory responder for the direct-mapped 16-bit cache: the memory-side end of its line interface.
//  Accepts one request per transaction, made of an optional 256-bit dirty-line write-back, an optional
//  256-bit line fill, or both (write-back first, then fill), and performs it with programmable latency.
//  Holds the line array and signals completion with a one-cycle done pulse. fill_data stays valid until the next fill.
// PARAMETERS
//  LINE_W   256  line width in bits (16 words x 16 bits)
//  ADDR_W   12   line address width ({tag[9:0], index[1:0]})
//  MEM_AW   8    array address bits; array holds 2**MEM_AW lines; only addr[MEM_AW-1:0] is used (upper bits alias)
//  WR_LAT   4    cycles spent in the write-back phase, 1..255
//  RD_LAT   6    cycles spent in the fill phase, 1..255
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       reset, synchronous, active-high
//  req_valid  in   1       request present; sampled only while req_ready=1
//  req_ready  out  1       high only in IDLE
//  req_wb     in   1       request includes a write-back of wb_data to wb_addr
//  req_fill   in   1       request includes a line read from fill_addr
//  wb_addr    in   ADDR_W  write-back line address
//  wb_data    in   LINE_W  write-back line, word k at [16k+15:16k]
//  fill_addr  in   ADDR_W  fill line address
//  fill_data  out  LINE_W  registered fill result, same word packing as wb_data
//  done       out  1       one-cycle pulse: transaction complete
//  busy       out  1       high whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, busy=0, done=0, fill_data=0, counter=0. Array contents are not cleared
//    and are preserved across rst.
//  - Accept: the edge with state=IDLE & req_valid=1 (i.e. handshake). On that edge, latch req_wb, req_fill,
//    both addresses and wb_data. After acceptance, inputs are don't-care until req_ready returns.
//  - req_valid while busy: ignored, never queued.
//  - FSM: IDLE -> WB if wb, else FILL if fill, else RESP. WB -> FILL if fill, else RESP. FILL -> RESP. RESP -> IDLE.
//  - WB: lasts exactly WR_LAT cycles. Down-counter is loaded with WR_LAT-1 on entry.
//    The array write of the latched line occurs on the last WB cycle only.
//  - FILL: lasts exactly RD_LAT cycles. The array is read on the last FILL cycle and fill_data is
//    registered on that edge.
//  - RESP: lasts 1 cycle. done=1 only in this cycle. fill_data is updated only by a fill.
//  - Latency: done is high in cycle N = wb*WR_LAT + fill*RD_LAT + 1 after the accept edge.
//    req_ready returns high in cycle N+1.
//  - Same address in WB and FILL (after aliasing): the fill returns the just-written wb_data,
//    because the write commits before the read.
//  - Empty request (wb=0, fill=0): done 1 cycle after accept. No array or fill_data change.
//  - rst mid-transaction: abort immediately to reset values. An uncommitted WB write is dropped.
//    Already-committed writes persist.
//  - Counter is 8 bits wide. WR_LAT/RD_LAT of 0 are illegal and asserted in simulation.
// TESTING
//  1 WB only: wb_addr=0x005, wb_data=A (word k = 16'hA000+k) -> req_ready low cycles 1..5, done in cycle 5,
//    busy drops in cycle 6.
//  2 Fill only: fill_addr=0x005 -> done in cycle 7, fill_data==A; fill_data holds A after a following empty request.
//  3 Combined: wb 0x00A<-B, fill 0x005 -> done in cycle 11, fill_data==A; then fill 0x00A -> B.
//  4 Same-address combined: wb 0x003<-C, fill 0x003 -> done in cycle 11, fill_data==C.
//  5 Alias plus ignore: wb 0x105<-D with req_valid toggling while busy -> only one done; fill 0x005 -> D.
//  6 Reset mid-WB: prime 0x007=E, then start wb 0x007<-F and assert rst in WB cycle 2 -> outputs at reset
//    values next cycle; fill 0x007 -> E.

Source files
------------

// File: rtl/line_mem_responder.sv
// Memory-side responder for the cache line interface: optional write-back then optional fill,
// each with a fixed latency, finishing with a one-cycle done pulse.
module line_mem_responder #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned MEM_AW = 8,
  parameter int unsigned WR_LAT = 4,
  parameter int unsigned RD_LAT = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wb,
  input  logic              req_fill,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [LINE_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_data,
  output logic              done,
  output logic              busy
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEPTH = 1 << MEM_AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              mem_we, mem_re;
  logic              accept;

  logic              wb_q, fill_q;
  logic [MEM_AW-1:0] wb_idx_q, fill_idx_q;
  logic [LINE_W-1:0] wb_data_q;

  logic [LINE_W-1:0] mem [DEPTH];

  // Upper address bits alias onto the same array line.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{wb_addr[ADDR_W-1:MEM_AW], fill_addr[ADDR_W-1:MEM_AW]};

  assign accept = (state == S_IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_RESP);
    end
  end

  // Next state, phase counter, and the single-cycle array write/read strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_wb) begin
            state_nxt = S_WB;
            cnt_nxt   = CNT_W'(WR_LAT - 1);
          end else if (req_fill) begin
            state_nxt = S_FILL;
            cnt_nxt   = CNT_W'(RD_LAT - 1);
          end else begin
            state_nxt = S_RESP;
          end
        end
      end
      S_WB: begin
        if (cnt == '0) begin
          mem_we = 1'b1;
          if (fill_q) begin
            state_nxt = S_FILL;
            cnt_nxt   = CNT_W'(RD_LAT - 1);
          end else begin
            state_nxt = S_RESP;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_FILL: begin
        if (cnt == '0) begin
          mem_re    = 1'b1;
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture at the handshake; held for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q       <= 1'b0;
      fill_q     <= 1'b0;
      wb_idx_q   <= '0;
      fill_idx_q <= '0;
      wb_data_q  <= '0;
    end else if (accept) begin
      wb_q       <= req_wb;
      fill_q     <= req_fill;
      wb_idx_q   <= wb_addr[MEM_AW-1:0];
      fill_idx_q <= fill_addr[MEM_AW-1:0];
      wb_data_q  <= wb_data;
    end
  end

  // Line array survives reset; only the final write-back cycle commits.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[wb_idx_q] <= wb_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_data <= '0;
    end else if (mem_re) begin
      fill_data <= mem[fill_idx_q];
    end
  end

  always_ff @(posedge clk) begin
    lat_range_a: assert (WR_LAT >= 1 && WR_LAT <= 255 && RD_LAT >= 1 && RD_LAT <= 255)
      else $error("line_mem_responder: WR_LAT/RD_LAT must be in 1..255");
  end

  logic unused_wb_q;
  assign unused_wb_q = wb_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: latency, data return, aliasing, busy-ignore and reset abort.
module tb_line_mem_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_wb = 1'b0;
  logic         req_fill = 1'b0;
  logic [11:0]  wb_addr = '0;
  logic [255:0] wb_data = '0;
  logic [11:0]  fill_addr = '0;
  logic [255:0] fill_data;
  logic         done;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  int   done_cyc, ready_cyc, done_cnt;
  logic busy_at_ready;

  logic [255:0] line_a, line_b, line_c, line_d, line_e, line_f;

  always #5 clk = ~clk;

  line_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wb    (req_wb),
    .req_fill  (req_fill),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .fill_addr (fill_addr),
    .fill_data (fill_data),
    .done      (done),
    .busy      (busy)
  );

  function automatic logic [255:0] make_line(input logic [15:0] base);
    logic [255:0] l;
    for (int k = 0; k < 16; k++) l[16*k +: 16] = base + 16'(k);
    return l;
  endfunction

  // Issue one request from IDLE and observe until req_ready returns (cycle 1 = first cycle after accept).
  task automatic run_req(input logic wb, input logic fill, input logic [11:0] wa,
                         input logic [255:0] wd, input logic [11:0] fa, input bit toggle);
    done_cyc = 0; ready_cyc = 0; done_cnt = 0; busy_at_ready = 1'bx;
    req_valid = 1'b1; req_wb = wb; req_fill = fill;
    wb_addr = wa; wb_data = wd; fill_addr = fa;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (req_ready === 1'b1) begin
        ready_cyc = c;
        busy_at_ready = busy;
        break;
      end
      if (toggle) begin
        req_valid = c[0]; req_wb = 1'b1; req_fill = 1'b1;
        wb_addr = 12'h0FF; wb_data = '1; fill_addr = 12'h0FF;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (fill_data !== 256'd0) begin n_fail++; $display("FAIL reset_fill_data: got %h expected 0", fill_data); end
    rst = 1'b0;
  endtask

  task automatic test_wb_only;
    run_req(1'b1, 1'b0, 12'h005, line_a, 12'h000, 1'b0);
    n_tests++; if (done_cyc !== 5) begin n_fail++; $display("FAIL wb_done_cycle: got %0d expected 5", done_cyc); end
    n_tests++; if (ready_cyc !== 6) begin n_fail++; $display("FAIL wb_ready_cycle: got %0d expected 6", ready_cyc); end
    n_tests++; if (busy_at_ready !== 1'b0) begin n_fail++; $display("FAIL wb_busy_drop: got %b expected 0", busy_at_ready); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL wb_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_fill_only;
    run_req(1'b0, 1'b1, 12'h000, '0, 12'h005, 1'b0);
    n_tests++; if (done_cyc !== 7) begin n_fail++; $display("FAIL fill_done_cycle: got %0d expected 7", done_cyc); end
    n_tests++; if (ready_cyc !== 8) begin n_fail++; $display("FAIL fill_ready_cycle: got %0d expected 8", ready_cyc); end
    n_tests++; if (fill_data !== line_a) begin n_fail++; $display("FAIL fill_data_a: got %h expected %h", fill_data, line_a); end
    run_req(1'b0, 1'b0, 12'h0AA, line_f, 12'h0AA, 1'b0);
    n_tests++; if (done_cyc !== 1) begin n_fail++; $display("FAIL empty_done_cycle: got %0d expected 1", done_cyc); end
    n_tests++; if (ready_cyc !== 2) begin n_fail++; $display("FAIL empty_ready_cycle: got %0d expected 2", ready_cyc); end
    n_tests++; if (fill_data !== line_a) begin n_fail++; $display("FAIL empty_holds_fill: got %h expected %h", fill_data, line_a); end
  endtask

  task automatic test_combined;
    run_req(1'b1, 1'b1, 12'h00A, line_b, 12'h005, 1'b0);
    n_tests++; if (done_cyc !== 11) begin n_fail++; $display("FAIL comb_done_cycle: got %0d expected 11", done_cyc); end
    n_tests++; if (fill_data !== line_a) begin n_fail++; $display("FAIL comb_fill_a: got %h expected %h", fill_data, line_a); end
    run_req(1'b0, 1'b1, 12'h000, '0, 12'h00A, 1'b0);
    n_tests++; if (fill_data !== line_b) begin n_fail++; $display("FAIL comb_fill_b: got %h expected %h", fill_data, line_b); end
  endtask

  task automatic test_same_addr;
    run_req(1'b1, 1'b1, 12'h003, line_c, 12'h003, 1'b0);
    n_tests++; if (done_cyc !== 11) begin n_fail++; $display("FAIL same_done_cycle: got %0d expected 11", done_cyc); end
    n_tests++; if (fill_data !== line_c) begin n_fail++; $display("FAIL same_fill_c: got %h expected %h", fill_data, line_c); end
  endtask

  task automatic test_alias_ignore;
    run_req(1'b1, 1'b0, 12'h105, line_d, 12'h000, 1'b1);
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
    n_tests++; if (done_cyc !== 5) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d expected 5", done_cyc); end
    n_tests++; if (ready_cyc !== 6) begin n_fail++; $display("FAIL ignore_ready_cycle: got %0d expected 6", ready_cyc); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL ignore_no_extra_done: got %b expected 0", done); end
    run_req(1'b0, 1'b1, 12'h000, '0, 12'h005, 1'b0);
    n_tests++; if (fill_data !== line_d) begin n_fail++; $display("FAIL alias_fill_d: got %h expected %h", fill_data, line_d); end
  endtask

  task automatic test_reset_mid_wb;
    run_req(1'b1, 1'b0, 12'h007, line_e, 12'h000, 1'b0);
    req_valid = 1'b1; req_wb = 1'b1; req_fill = 1'b0; wb_addr = 12'h007; wb_data = line_f;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstwb_busy_c1: got %b expected 1", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstwb_ready: got %b expected 1", req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstwb_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstwb_done: got %b expected 0", done); end
    n_tests++; if (fill_data !== 256'd0) begin n_fail++; $display("FAIL rstwb_fill_data: got %h expected 0", fill_data); end
    run_req(1'b0, 1'b1, 12'h000, '0, 12'h007, 1'b0);
    n_tests++; if (done_cyc !== 7) begin n_fail++; $display("FAIL rstwb_fill_done: got %0d expected 7", done_cyc); end
    n_tests++; if (fill_data !== line_e) begin n_fail++; $display("FAIL rstwb_fill_e: got %h expected %h", fill_data, line_e); end
  endtask

  initial begin
    line_a = make_line(16'hA000);
    line_b = make_line(16'hB000);
    line_c = make_line(16'hC000);
    line_d = make_line(16'hD000);
    line_e = make_line(16'hE000);
    line_f = make_line(16'hF000);
    test_reset();
    test_wb_only();
    test_fill_only();
    test_combined();
    test_same_addr();
    test_alias_ignore();
    test_reset_mid_wb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
